// File: rtl/stack_ctrl.sv
// Stack controller: arbitrates two requesters (CPU, interrupt unit) onto a
// single stack-pointer unit and a shared memory port. One push or pop is in
// flight at a time; memory waits are bounded by TIMEOUT cycles.
module stack_ctrl #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic        op0,
   input  logic        op1,
   input  logic [3:0]  id0,
   input  logic [3:0]  id1,
   input  logic [15:0] wdata0,
   input  logic [15:0] wdata1,
   output logic        done0,
   output logic        done1,
   output logic        err,
   output logic [15:0] rdata,
   output logic        s,
   output logic        push,
   output logic        pop,
   output logic [3:0]  arg,
   output logic        readIt,
   input  logic [15:0] stackAddr,
   input  logic        stackoverflow,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CMD  = 3'd1,
      WR   = 3'd2,
      RD   = 3'd3,
      REL  = 3'd4,
      DONE = 3'd5
   } state_t;

   // Last wait cycle: the counter starts at 0 on the first WR/RD cycle.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   state_t      state_nxt;
   logic        gnt;        // 0 = requester 0 owns the operation
   logic        last;       // requester granted most recently
   logic        op_q;       // 1 = push
   logic [3:0]  id_q;
   logic [15:0] wdata_q;
   logic [15:0] addr_q;
   logic        err_q;
   logic [15:0] rdata_q;
   logic [7:0]  cnt;
   logic        win;
   logic        timeout_hit;

   // On a tie the requester that was not granted last wins.
   assign win         = (req0 && req1) ? ~last : req1;
   assign timeout_hit = (cnt == TO_LAST);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state selection.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               state_nxt = CMD;
            end else begin
               state_nxt = IDLE;
            end
         end
         CMD: begin
            if (op_q && stackoverflow) begin
               state_nxt = DONE;
            end else if (op_q) begin
               state_nxt = WR;
            end else begin
               state_nxt = RD;
            end
         end
         WR: begin
            if (mem_ack || timeout_hit) begin
               state_nxt = DONE;
            end else begin
               state_nxt = WR;
            end
         end
         RD: begin
            if (mem_ack) begin
               state_nxt = REL;
            end else if (timeout_hit) begin
               // Pointer is left untouched when the read never completes.
               state_nxt = DONE;
            end else begin
               state_nxt = RD;
            end
         end
         REL:     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operation latches, wait counter, error/result capture and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt     <= 1'b0;
         last    <= 1'b1;
         op_q    <= 1'b0;
         id_q    <= 4'd0;
         wdata_q <= 16'd0;
         addr_q  <= 16'd0;
         err_q   <= 1'b0;
         rdata_q <= 16'd0;
         cnt     <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  gnt     <= win;
                  op_q    <= win ? op1    : op0;
                  id_q    <= win ? id1    : id0;
                  wdata_q <= win ? wdata1 : wdata0;
               end
            end
            CMD: begin
               addr_q <= stackAddr;
               cnt    <= 8'd0;
               err_q  <= op_q & stackoverflow;
            end
            WR: begin
               if (mem_ack) begin
                  err_q <= 1'b0;
               end else if (timeout_hit) begin
                  err_q <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            RD: begin
               if (mem_ack) begin
                  rdata_q <= mem_rdata;
               end else if (timeout_hit) begin
                  err_q <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            REL: begin
               // Stack-pointer unit flags an empty stack while readIt is high.
               err_q <= stackoverflow;
            end
            DONE: begin
               last <= gnt;
            end
            default: begin
               cnt <= 8'd0;
            end
         endcase
      end
   end

   // Outputs decoded from registered state only, so they are glitch-free
   // with respect to the inputs and clear immediately on reset.
   always_comb begin
      s         = (state == CMD);
      push      = (state == CMD) &  op_q;
      pop       = (state == CMD) & ~op_q;
      arg       = ((state == CMD) || (state == REL)) ? id_q : 4'd0;
      readIt    = (state == REL);
      mem_we    = (state == WR);
      mem_re    = (state == RD);
      mem_addr  = ((state == WR) || (state == RD)) ? addr_q : 16'd0;
      mem_wdata = (state == WR) ? wdata_q : 16'd0;
      done0     = (state == DONE) & ~gnt;
      done1     = (state == DONE) &  gnt;
      err       = (state == DONE) &  err_q;
      rdata     = rdata_q;
   end

endmodule
